// File: rtl/draw_pkg.sv
// Shared types and defaults for the VGA drawing path: blitter state encoding,
// visible screen size and the ROM address width used by the adapter and ROM wrappers.
package draw_pkg;

  localparam int ADDR_W_DEF   = 16;
  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/raster_counter.sv
// Column/row scan counter for a width x height rectangle, with clear, enable
// and a flag marking the final pixel of the scan.
module raster_counter #(
  parameter int X_W = 10,
  parameter int Y_W = 9
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           clear,
  input  logic           en,
  input  logic [X_W-1:0] width,
  input  logic [Y_W-1:0] height,
  output logic [X_W-1:0] col,
  output logic [Y_W-1:0] row,
  output logic           last
);

  logic [X_W-1:0] col_d, col_q;
  logic [Y_W-1:0] row_d, row_q;
  logic           col_end;

  assign col_end = (col_q == width - X_W'(1));
  assign last    = col_end && (row_q == height - Y_W'(1));
  assign col     = col_q;
  assign row     = row_q;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (col_end) begin
        col_d = '0;
        row_d = last ? '0 : row_q + Y_W'(1);
      end else begin
        col_d = col_q + X_W'(1);
      end
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/draw_sprite.sv
// Raster blitter: scans a W x H rectangle at a screen origin, issuing sequential
// ROM addresses, and emits (x, y, plot) one cycle later to line up with ROM data.
module draw_sprite
  import draw_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [X_W-1:0]    x0,
  input  logic [Y_W-1:0]    y0,
  input  logic [X_W-1:0]    width,
  input  logic [Y_W-1:0]    height,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              hold,
  output logic [ADDR_W-1:0] address,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic              plot,
  output logic              busy,
  output logic              done
);

  state_e state_d, state_q;

  logic [X_W-1:0]    x0_d, x0_q, w_d, w_q, x_d, x_q;
  logic [Y_W-1:0]    y0_d, y0_q, h_d, h_q, y_d, y_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              plot_d, plot_q;

  logic              accept, issue, last;
  logic [X_W-1:0]    col;
  logic [Y_W-1:0]    row;
  logic [X_W:0]      x_sum;
  logic [Y_W:0]      y_sum;

  assign accept = (state_q == IDLE) && start;
  assign issue  = (state_q == RUN) && !hold;

  raster_counter #(.X_W(X_W), .Y_W(Y_W)) u_raster (
    .clk    (clk),
    .resetn (resetn),
    .clear  (accept),
    .en     (issue),
    .width  (w_q),
    .height (h_q),
    .col    (col),
    .row    (row),
    .last   (last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (width == '0 || height == '0) ? FINISH : RUN;
      RUN:     if (issue && last) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == FINISH);
  end

  // Sums are one bit wider so an origin near the edge cannot wrap back on-screen.
  assign x_sum = {1'b0, x0_q} + {1'b0, col};
  assign y_sum = {1'b0, y0_q} + {1'b0, row};

  always_comb begin
    x0_d   = accept ? x0        : x0_q;
    y0_d   = accept ? y0        : y0_q;
    w_d    = accept ? width     : w_q;
    h_d    = accept ? height    : h_q;
    addr_d = addr_q;
    if (accept)     addr_d = base_addr;
    else if (issue) addr_d = addr_q + ADDR_W'(1);
    plot_d = issue && (x_sum < (X_W+1)'(SCREEN_W)) && (y_sum < (Y_W+1)'(SCREEN_H));
    x_d    = issue ? x_sum[X_W-1:0] : x_q;
    y_d    = issue ? y_sum[Y_W-1:0] : y_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x0_q   <= '0;
      y0_q   <= '0;
      w_q    <= '0;
      h_q    <= '0;
      addr_q <= '0;
      plot_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      x0_q   <= x0_d;
      y0_q   <= y0_d;
      w_q    <= w_d;
      h_q    <= h_d;
      addr_q <= addr_d;
      plot_q <= plot_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  assign address = addr_q;
  assign plot    = plot_q;
  assign x       = x_q;
  assign y       = y_q;

endmodule

// File: doc/draw_sprite.md
# draw_sprite

Parametrised raster blitter for the VGA drawing path. On a start pulse it scans a W×H rectangle at a programmable screen origin and issues sequential image-ROM addresses from a programmable base. It delivers (x, y, plot) aligned with the synchronous ROM's data, so a board, cell or number tile can be drawn by one engine. It adds a start/busy/done handshake, a hold stall, screen clipping and zero-size handling, and sits between the game controller and the VGA adapter's plot port.

## Interface
- X_W, 10, x coordinate / width bits
- Y_W, 9, y coordinate / height bits
- ADDR_W, 16, ROM address bits
- SCREEN_W, 320, visible columns; x ≥ SCREEN_W is clipped
- SCREEN_H, 240, visible rows; y ≥ SCREEN_H is clipped
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  request a draw; accepted only in IDLE
- x0  in  X_W  origin column, latched on accept
- y0  in  Y_W  origin row, latched on accept
- width  in  X_W  rectangle width, latched on accept
- height  in  Y_W  rectangle height, latched on accept
- base_addr  in  ADDR_W  ROM address of pixel (0,0), latched on accept
- hold  in  1  stall; freezes address issue while high
- address  out  ADDR_W  ROM read address
- x  out  X_W  pixel column, aligned with ROM data
- y  out  Y_W  pixel row, aligned with ROM data
- plot  out  1  write strobe for the current x, y and ROM data
- busy  out  1  engine owns the ROM/plot path
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, FINISH.
- IDLE, start=1:
  - Latch all inputs; col=row=0; address←base_addr.
  - If width=0 or height=0, go to FINISH. Otherwise go to RUN.
- RUN, each cycle with hold=0 (issue cycle):
  - Pixel (col,row) is issued.
  - Next cycle: col+1, address+1.
  - At col=width−1: col←0, row+1.
  - After issuing (width−1,height−1), go to FINISH.
- RUN with hold=1: col, row, address and state are frozen, and no pixel is issued.
- Output stage (registered one cycle after issue):
  - plot=1 iff the previous cycle was an issue cycle and the pixel is on-screen.
  - x=x0+col and y=y0+row of that pixel.
  - The sum is computed at X_W+1 / Y_W+1 bits and compared against SCREEN_W/SCREEN_H.
  - Outputs x and y are the truncated low bits.
- Clipped pixels still consume an address and a cycle, with plot=0.
- FINISH: done=1 for one cycle, then go to IDLE.
  - The final pixel's plot comes out in the FINISH cycle, so done coincides with the last plot.
  - hold has no effect in FINISH.
- The address wraps modulo 2^ADDR_W and never saturates.
- start while busy=1 is ignored, with no relatch.
- busy=1 in RUN and FINISH.

## Timing
- Reset (async, resetn=0): state=IDLE; address=0, x=0, y=0, plot=0, busy=0, done=0; all latched fields cleared.
- Reset mid-draw aborts immediately; no done pulse is produced.
- Start accepted at edge 0:
  - Cycle 1: busy=1, address=base_addr.
  - Cycle 2: plot for (x0,y0).
- No hold: pixel k is issued in cycle k+1 and plotted in cycle k+2.
- Last plot and done both occur in cycle W·H+1; busy falls at cycle W·H+2.
- Each hold cycle in RUN delays every later event by exactly one cycle. plot=0 in the cycle after a held cycle.
- Zero size: done=1 in cycle 1, busy=1 only in cycle 1, and plot is never asserted.
- Start in the same cycle busy falls (IDLE) is accepted. Back-to-back draws therefore have a one-cycle gap.

## Structure
- Package draw_pkg holds:
  - the state typedef (IDLE/RUN/FINISH);
  - SCREEN_W/SCREEN_H defaults;
  - the ADDR_W default, shared with the VGA adapter and ROM wrappers.
- Natural sub-module: raster_counter.
  - Parametrised col/row counters with enable, load-to-zero and a `last` flag (col=width−1 && row=height−1).
- The top level holds the FSM, address counter, clipping compare and output register stage.

## Test plan
- x0=10, y0=20, w=3, h=2, base=100, hold=0:
  - addresses 100–105 in cycles 1–6;
  - plots (10,20),(11,20),(12,20),(10,21),(11,21),(12,21) in cycles 2–7;
  - done in cycle 7.
- Same draw with hold=1 in cycles 3–4:
  - address 102 held for three cycles;
  - plot=0 in cycles 4–5;
  - done in cycle 9; pixel sequence unchanged.
- x0=318, y0=239, w=4, h=2, base=0:
  - plots only at (318,239),(319,239);
  - 8 addresses issued;
  - done in cycle 9.
- w=0, h=5: done in cycle 1, no plot, address unchanged after return to IDLE.
- base=0xFFFE, w=4, h=1: addresses FFFE, FFFF, 0000, 0001.
- resetn low in cycle 4 of a 3×2 draw:
  - all outputs 0 asynchronously, no done;
  - a new start after release behaves as a fresh draw.
  - A start pulsed mid-draw (before reset) is ignored.
